// File: rtl/uart_axi_tx_fifo_pkg.sv
// ============================================================================
// Module : uart_axi_tx_fifo_pkg
// Brief  : Shared register map and FIFO constants for the UART AXI TX path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_axi_tx_fifo_pkg;

    localparam int          UART_FIFO_DEPTH = 16;
    localparam int          UART_FIFO_PTR_W = $clog2(UART_FIFO_DEPTH);
    localparam logic [4:0]  UART_REG_TR     = 5'h00;
    localparam logic [4:0]  UART_REG_LC     = 5'h0C;

    typedef enum logic [1:0] {
        FIFO_HOLD = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_axi_fifo_mem.sv
// ============================================================================
// Module : uart_axi_fifo_mem
// Brief  : DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_axi_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_axi_tx_fifo.sv
// ============================================================================
// Module : uart_axi_tx_fifo
// Brief  : Transmit-holding FIFO fed by AXI-lite TR writes, with sticky overrun.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_axi_tx_fifo
    import uart_axi_tx_fifo_pkg::*;
#(
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         wb_rst_i,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        addr_in,
    input  logic [DATA_WIDTH-1:0]        w_data_in,
    input  logic                         dlab,
    input  logic                         fifo_clr,
    input  logic                         tx_pop,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic                         tx_empty,
    output logic                         tx_full,
    output logic [$clog2(DEPTH):0]       tx_count,
    output logic                         tf_overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overrun;

    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_mem_we;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_push_req = we & (addr_in == ADDR_WIDTH'(UART_REG_TR)) & ~dlab;
    assign w_pop_ok   = tx_pop & ~w_empty;
    assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);
    // A flush in the same cycle discards the push, so storage must not see it either.
    assign w_mem_we   = w_push_ok & ~fifo_clr;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (fifo_clr) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (fifo_op(w_push_ok, w_pop_ok))
                FIFO_PUSH: r_count <= r_count + 1'b1;
                FIFO_POP:  r_count <= r_count - 1'b1;
                default:   r_count <= r_count;
            endcase
            if (w_push_ok) begin
                r_overrun <= 1'b0;
            end else if (w_push_req) begin
                r_overrun <= 1'b1;
            end
        end
    end

    uart_axi_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (wb_rst_i),
        .wr_en   (w_mem_we),
        .wr_addr (r_wr_ptr),
        .wr_data (w_data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (tx_data)
    );

    assign tx_empty   = w_empty;
    assign tx_full    = w_full;
    assign tx_count   = r_count;
    assign tf_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_axi_tx_fifo.sv
// ============================================================================
// Module : tb_uart_axi_tx_fifo
// Brief  : Randomized and directed checks of uart_axi_tx_fifo against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_axi_tx_fifo;
    import uart_axi_tx_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       we = 1'b0;
    logic [4:0] addr_in = '0;
    logic [7:0] w_data_in = '0;
    logic       dlab = 1'b0;
    logic       fifo_clr = 1'b0;
    logic       tx_pop = 1'b0;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       tf_overrun;

    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    uart_axi_tx_fifo dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .we         (we),
        .addr_in    (addr_in),
        .w_data_in  (w_data_in),
        .dlab       (dlab),
        .fifo_clr   (fifo_clr),
        .tx_pop     (tx_pop),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .tx_full    (tx_full),
        .tx_count   (tx_count),
        .tf_overrun (tf_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk_eq("count", 32'(tx_count), 32'(m_q.size()));
        chk_eq("empty", 32'(tx_empty), 32'(m_q.size() == 0));
        chk_eq("full", 32'(tx_full), 32'(m_q.size() == 16));
        chk_eq("overrun", 32'(tf_overrun), 32'(m_ovr));
        if (m_q.size() != 0) chk_eq("data", 32'(tx_data), 32'(m_q[0]));
    endtask

    // Model: one clock of the FIFO rules, applied to a plain queue.
    task automatic model_step();
        bit preq, pop_ok, push_ok;
        if (fifo_clr) begin
            m_q.delete();
            m_ovr = 1'b0;
        end else begin
            preq    = we && (addr_in == UART_REG_TR) && !dlab;
            pop_ok  = tx_pop && (m_q.size() > 0);
            push_ok = preq && ((m_q.size() < 16) || pop_ok);
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(w_data_in);
            if (push_ok) m_ovr = 1'b0;
            else if (preq) m_ovr = 1'b1;
        end
    endtask

    task automatic cyc(input logic c_we, input logic [4:0] c_a, input logic [7:0] c_d,
                       input logic c_dl, input logic c_clr, input logic c_pop);
        we = c_we; addr_in = c_a; w_data_in = c_d; dlab = c_dl; fifo_clr = c_clr; tx_pop = c_pop;
        model_step();
        @(posedge clk);
        #1;
        we = 1'b0; fifo_clr = 1'b0; tx_pop = 1'b0; dlab = 1'b0;
        chk_all();
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, UART_REG_TR, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, UART_REG_TR, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] last;
        bit         saw_aa;

        repeat (2) @(posedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("rst_empty", 32'(tx_empty), 32'd1);
        chk_eq("rst_data", 32'(tx_data), 32'h00);

        // Fill and drain in order
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk_eq("fill_full", 32'(tx_full), 32'd1);
        chk_eq("fill_count", 32'(tx_count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            chk_eq("drain_data", 32'(tx_data), 32'(i));
            pop();
        end
        chk_eq("drain_empty", 32'(tx_empty), 32'd1);

        // Overrun set on drop, cleared by the next accepted write
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hAA);
        chk_eq("ovr_set", 32'(tf_overrun), 32'd1);
        chk_eq("ovr_count", 32'(tx_count), 32'd16);
        pop();
        chk_eq("ovr_hold", 32'(tf_overrun), 32'd1);
        push(8'hBB);
        chk_eq("ovr_clr", 32'(tf_overrun), 32'd0);
        saw_aa = 1'b0;
        last = 8'h00;
        while (!tx_empty && m_q.size() > 0) begin
            if (tx_data == 8'hAA) saw_aa = 1'b1;
            last = tx_data;
            pop();
        end
        chk_eq("ovr_last", 32'(last), 32'hBB);
        chk_eq("ovr_no_aa", 32'(saw_aa), 32'd0);

        // Full with simultaneous push and pop, then pop while empty
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        cyc(1'b1, UART_REG_TR, 8'h55, 1'b0, 1'b0, 1'b1);
        chk_eq("fp_ovr", 32'(tf_overrun), 32'd0);
        chk_eq("fp_count", 32'(tx_count), 32'd16);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = tx_data;
            pop();
        end
        chk_eq("fp_last", 32'(last), 32'h55);
        pop();
        chk_eq("empty_pop", 32'(tx_count), 32'd0);

        // Address and dlab filter
        push(8'h11);
        cyc(1'b1, UART_REG_LC, 8'h99, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, UART_REG_TR, 8'h98, 1'b1, 1'b0, 1'b0);
        chk_eq("filter_count", 32'(tx_count), 32'd1);
        pop();

        // Wrap pointers twice, then flush with a concurrent push
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h80 + i));
            pop();
        end
        push(8'h01);
        push(8'h02);
        cyc(1'b1, UART_REG_TR, 8'h77, 1'b0, 1'b1, 1'b0);
        chk_eq("clr_count", 32'(tx_count), 32'd0);
        chk_eq("clr_empty", 32'(tx_empty), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic       r_we, r_dl, r_clr, r_pop;
            logic [4:0] r_a;
            r_we  = ($urandom_range(99) < 60);
            r_a   = ($urandom_range(9) == 0) ? UART_REG_LC : UART_REG_TR;
            r_dl  = ($urandom_range(19) == 0);
            r_clr = ($urandom_range(49) == 0);
            r_pop = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 30 : 65));
            cyc(r_we, r_a, 8'($urandom), r_dl, r_clr, r_pop);
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        we = 1'b1; addr_in = UART_REG_TR; w_data_in = 8'hEE;
        wb_rst_i = 1'b1;
        #1;
        m_q.delete();
        m_ovr = 1'b0;
        chk_eq("arst_empty", 32'(tx_empty), 32'd1);
        chk_eq("arst_count", 32'(tx_count), 32'd0);
        chk_eq("arst_ovr", 32'(tf_overrun), 32'd0);
        chk_eq("arst_data", 32'(tx_data), 32'h00);
        we = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk_all();
        push(8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
